// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep initiator for universal_binary_counter: load base, count up to all-ones,
// dwell, count down to zero, dwell, repeat n_sweeps round trips, then clear; checks q on the fly.
module counter_sweep_ctrl #(
  parameter int N     = 8,
  parameter int DWELL = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         abort,
  input  logic [N-1:0] base,
  input  logic [7:0]   n_sweeps,
  input  logic [N-1:0] q,
  input  logic         max_tick,
  input  logic         min_tick,
  output logic         syn_clr,
  output logic         load,
  output logic         en,
  output logic         up,
  output logic [N-1:0] d,
  output logic         busy,
  output logic         done,
  output logic [7:0]   sweep_cnt,
  output logic         err
);

  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

  typedef enum logic [2:0] {IDLE, LOAD, UP, PTOP, DOWN, PBOT, CLEAR} state_t;

  state_t        state;
  logic [DW-1:0] dwell_cnt;
  logic [N-1:0]  exp_val;
  logic          finish_pending;

  // Gating en with the ticks keeps the counter from ever wrapping.
  always_comb begin
    load    = (state == LOAD);
    syn_clr = (state == CLEAR);
    up      = !((state == DOWN) || (state == PBOT));
    en      = ((state == UP) && !max_tick) || ((state == DOWN) && !min_tick);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      dwell_cnt      <= '0;
      exp_val        <= '0;
      finish_pending <= 1'b0;
      d              <= '0;
      done           <= 1'b0;
      sweep_cnt      <= '0;
      err            <= 1'b0;
    end else begin
      done <= 1'b0;

      // Shadow of what the counter should hold next cycle.
      case (state)
        LOAD:    exp_val <= d;
        CLEAR:   exp_val <= '0;
        default: if (en) exp_val <= up ? exp_val + 1'b1 : exp_val - 1'b1;
      endcase

      if ((state != IDLE) && (state != LOAD) && (q != exp_val))
        err <= 1'b1;

      if ((state != IDLE) && abort) begin
        state          <= CLEAR;
        dwell_cnt      <= '0;
        finish_pending <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              d              <= base;
              sweep_cnt      <= '0;
              err            <= 1'b0;
              finish_pending <= 1'b0;
              state          <= LOAD;
            end
          end
          LOAD: state <= UP;
          UP: begin
            if (max_tick) begin
              dwell_cnt <= '0;
              state     <= PTOP;
            end
          end
          PTOP: begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              state     <= DOWN;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          DOWN: begin
            if (min_tick) begin
              sweep_cnt <= sweep_cnt + 8'd1;
              dwell_cnt <= '0;
              if ((n_sweeps != 8'd0) && (sweep_cnt + 8'd1 == n_sweeps)) begin
                finish_pending <= 1'b1;
                state          <= CLEAR;
              end else begin
                state <= PBOT;
              end
            end
          end
          PBOT: begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              state     <= UP;
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
          CLEAR: begin
            done           <= finish_pending;
            finish_pending <= 1'b0;
            state          <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl driving a behavioural 3-bit counter; expected per-cycle
// behaviour is generated as a queue from the sweep rules and compared cycle by cycle.
module tb_counter_sweep_ctrl;
  localparam int N     = 3;
  localparam int DWELL = 2;
  localparam int TOP   = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] base = '0;
  logic [7:0]   n_sweeps = 8'd0;
  logic [N-1:0] q;
  logic         max_tick, min_tick;
  logic         syn_clr, load, en, up, busy, done, err;
  logic [N-1:0] d;
  logic [7:0]   sweep_cnt;

  logic [N-1:0] cnt_q;
  logic         q_force = 1'b0;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [N-1:0] q;
    logic [4:0]   ctl;   // {load, syn_clr, en, up, busy}
  } exp_t;
  exp_t model_q[$];

  always #5 clk = ~clk;

  // Stand-in for universal_binary_counter: clear > load > count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     cnt_q <= '0;
    else if (syn_clr) cnt_q <= '0;
    else if (load)    cnt_q <= d;
    else if (en)      cnt_q <= up ? cnt_q + 1'b1 : cnt_q - 1'b1;
  end

  assign q        = q_force ? 3'd5 : cnt_q;
  assign max_tick = (cnt_q == 3'(TOP));
  assign min_tick = (cnt_q == 3'd0);

  counter_sweep_ctrl #(.N(N), .DWELL(DWELL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base(base),
    .n_sweeps(n_sweeps), .q(q), .max_tick(max_tick), .min_tick(min_tick),
    .syn_clr(syn_clr), .load(load), .en(en), .up(up), .d(d), .busy(busy),
    .done(done), .sweep_cnt(sweep_cnt), .err(err)
  );

  // Expected cycles from LOAD through CLEAR for a run of nsw round trips.
  function automatic void build(input int b, input int nsw);
    model_q.delete();
    model_q.push_back('{q: 3'd0, ctl: 5'b10011});
    for (int t = 0; t < nsw; t++) begin
      if (t > 0)
        for (int k = 0; k < DWELL; k++) model_q.push_back('{q: 3'd0, ctl: 5'b00001});
      for (int v = (t == 0) ? b : 0; v <= TOP; v++)
        model_q.push_back('{q: 3'(v), ctl: {2'b00, (v != TOP), 2'b11}});
      for (int k = 0; k < DWELL; k++) model_q.push_back('{q: 3'(TOP), ctl: 5'b00011});
      for (int v = TOP; v >= 0; v--)
        model_q.push_back('{q: 3'(v), ctl: {2'b00, (v != 0), 2'b01}});
    end
    model_q.push_back('{q: 3'd0, ctl: 5'b01011});
  endfunction

  task automatic check_idle(input string name, input logic exp_done, input logic [7:0] exp_sc,
                            input logic exp_err);
    checks++;
    if ({load, syn_clr, en, up, busy, done} !== {5'b00010, exp_done}) begin
      errors++;
      $display("FAIL %s ctl: got load/clr/en/up/busy/done=%b want %b", name,
               {load, syn_clr, en, up, busy, done}, {5'b00010, exp_done});
    end
    checks++;
    if (sweep_cnt !== exp_sc) begin
      errors++;
      $display("FAIL %s sweep_cnt: got %0d want %0d", name, sweep_cnt, exp_sc);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b want %b", name, err, exp_err);
    end
    checks++;
    if (q !== 3'd0) begin
      errors++;
      $display("FAIL %s q: got %0d want 0", name, q);
    end
  endtask

  // One cycle of the expected stream; returns after comparing entry i.
  task automatic check_entry(input string name, input int i, input int b, input logic exp_err,
                             input logic skip_q);
    checks++;
    if (!skip_q && q !== model_q[i].q) begin
      errors++;
      $display("FAIL %s q[%0d]: got %0d want %0d", name, i, q, model_q[i].q);
    end
    checks++;
    if ({load, syn_clr, en, up, busy} !== model_q[i].ctl) begin
      errors++;
      $display("FAIL %s ctl[%0d]: got %b want %b", name, i, {load, syn_clr, en, up, busy},
               model_q[i].ctl);
    end
    checks++;
    if (d !== 3'(b)) begin
      errors++;
      $display("FAIL %s d[%0d]: got %0d want %0d", name, i, d, b);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err[%0d]: got %b want %b", name, i, err, exp_err);
    end
  endtask

  task automatic run_stream(input string name, input int b, input int nsw,
                            input int force_idx, input int poke_idx);
    build(b, nsw);
    @(negedge clk);
    base = 3'(b); n_sweeps = 8'(nsw); start = 1'b1;
    for (int i = 0; i < model_q.size(); i++) begin
      @(negedge clk);
      start   = (i == poke_idx);
      if (i == poke_idx) base = 3'(b + 3);
      q_force = (i == force_idx);
      #1;
      check_entry(name, i, b, (force_idx >= 0) && (i > force_idx), (i == force_idx));
    end
    @(negedge clk);
    start = 1'b0; q_force = 1'b0; base = 3'(b);
    #1 check_idle({name, " end"}, 1'b1, 8'(nsw), force_idx >= 0);
    @(negedge clk);
    #1 check_idle({name, " after"}, 1'b0, 8'(nsw), force_idx >= 0);
    $display("run %s base=%0d n_sweeps=%0d cycles=%0d errors=%0d", name, b, nsw,
             model_q.size(), errors);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({syn_clr, load, en, up, d, busy, done, sweep_cnt, err, q} !== {4'b0001, 3'd0, 2'b00, 8'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL reset outputs: got %b want %b", {syn_clr, load, en, up, d, busy, done, sweep_cnt, err, q},
               {4'b0001, 3'd0, 2'b00, 8'd0, 1'b0, 3'd0});
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1 check_idle("reset released", 1'b0, 8'd0, 1'b0);
    $display("reset checked errors=%0d", errors);
  endtask

  task automatic test_abort();
    int b;
    int hits;
    int idx;
    b = $urandom_range(0, TOP);
    build(b, 2);
    hits = 0; idx = -1;
    for (int i = 0; i < model_q.size(); i++)
      if (model_q[i].q == 3'd4 && model_q[i].ctl == 5'b00101) begin
        hits++;
        if (hits == 2 && idx < 0) idx = i;
      end
    @(negedge clk);
    base = 3'(b); n_sweeps = 8'd0; start = 1'b1;
    for (int i = 0; i <= idx; i++) begin
      @(negedge clk);
      start = 1'b0;
      #1 check_entry("abort", i, b, 1'b0, 1'b0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if ({q, load, syn_clr, en, up, busy} !== {3'd3, 5'b01011}) begin
      errors++;
      $display("FAIL abort clear: got q/ctl=%b want %b", {q, load, syn_clr, en, up, busy}, {3'd3, 5'b01011});
    end
    @(negedge clk);
    #1 check_idle("abort idle", 1'b0, 8'd1, 1'b0);
    @(negedge clk);
    #1 check_idle("abort idle2", 1'b0, 8'd1, 1'b0);
    $display("run abort base=%0d at index %0d errors=%0d", b, idx, errors);
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    base = 3'($urandom_range(0, TOP)); n_sweeps = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat ($urandom_range(3, 15)) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({syn_clr, load, en, up, d, busy, done, sweep_cnt, err, q} !== {4'b0001, 3'd0, 2'b00, 8'd0, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL midrun reset: got %b want %b", {syn_clr, load, en, up, d, busy, done, sweep_cnt, err, q},
               {4'b0001, 3'd0, 2'b00, 8'd0, 1'b0, 3'd0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 check_idle("midrun reset idle", 1'b0, 8'd0, 1'b0);
    $display("midrun reset checked errors=%0d", errors);
  endtask

  initial begin
    test_reset();
    run_stream("single", 6, 1, -1, -1);
    run_stream("multi", 0, 3, -1, -1);
    run_stream("edge_base", 7, 1, -1, -1);
    test_abort();
    run_stream("err_detect", 0, 1, 4, -1);
    run_stream("err_cleared", 2, 1, -1, -1);
    run_stream("start_ignored", 1, 2, -1, 5);
    for (int r = 0; r < 4; r++)
      run_stream("random", $urandom_range(0, TOP), $urandom_range(1, 3), -1, -1);
    test_reset_midrun();
    run_stream("back_to_back", 4, 1, -1, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
